// File: rtl/cfg_regfile_pkg.sv
// Shared constants and types for the configuration register bank.
//   ADDR_PTR / ADDR_CTRL : fixed addresses of the pointer and control registers
//   CTRL_*               : bit positions inside a control-register write
//   ST_*                 : bit positions inside the readback status word
//   commit_state_t       : commit sequencer states
package cfg_regfile_pkg;

  localparam int ADDR_PTR  = 0;
  localparam int ADDR_CTRL = 1;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_LOCK    = 1;
  localparam int CTRL_CLR_ERR = 2;

  localparam int ST_PEND  = 0;
  localparam int ST_LOCK  = 1;
  localparam int ST_ERR   = 2;
  localparam int ST_DIRTY = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

endpackage

// File: rtl/cfg_reg_slot.sv
// One double-buffered configuration register: a shadow copy written by the
// host and an active copy loaded from the shadow on commit.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   wr_en, wr_data    shadow write strobe and data
//   commit_en         copy shadow into active at this edge
//   shadow, active    current shadow and active values
//   differs           shadow and active disagree
module cfg_reg_slot #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit_en,
  output logic [DATA_W-1:0] shadow,
  output logic [DATA_W-1:0] active,
  output logic              differs
);

  // NOTE: non-blocking assignments mean active picks up the pre-edge shadow,
  // so a shadow write landing on the commit edge is not transferred.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= RESET_VAL;
      active <= RESET_VAL;
    end else begin
      if (wr_en)     shadow <= wr_data;
      if (commit_en) active <= shadow;
    end
  end

  assign differs = (shadow != active);

endmodule

// File: rtl/cfg_regfile.sv
// Double-buffered configuration register bank for the oscillator datapath.
// Host writes land in shadow registers; a commit (immediate or aligned to
// frame_sync) copies all shadows to the active registers at once.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   load, address,   host write strobe, address and data
//   data_in
//   rd_en            readback request at the current pointer
//   frame_sync       frame boundary pulse (used when SYNC_COMMIT=1)
//   active_regs      committed register values, register i at [i*DATA_W +: DATA_W]
//   data_out,        readback data and its one-cycle qualifier
//   data_valid
//   commit_pending   commit requested and waiting for frame_sync
//   dirty            some shadow differs from its active register
//   locked           shadow writes blocked until reset
//   wr_err           sticky write-error flag
module cfg_regfile
  import cfg_regfile_pkg::*;
#(
  parameter int                         DATA_W      = 8,
  parameter int                         ADDR_W      = 3,
  parameter int                         FIRST_ADDR  = 2,
  parameter int                         NUM_REGS    = 5,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS  = {8'h10, 8'h1b, 8'h7d, 8'h00, 8'h20},
  parameter bit                         SYNC_COMMIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_en,
  input  logic                       frame_sync,
  output logic [NUM_REGS*DATA_W-1:0] active_regs,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic                       commit_pending,
  output logic                       dirty,
  output logic                       locked,
  output logic                       wr_err
);

  localparam int LAST_ADDR = FIRST_ADDR + NUM_REGS - 1;

  commit_state_t         state, state_next;
  logic [ADDR_W-1:0]     ptr;
  logic [31:0]           addr_ext, ptr_ext;
  logic                  wr_ptr, wr_ctrl, commit_req, commit_en;
  logic                  in_range, above_range, lock_err, range_err;
  logic [NUM_REGS-1:0]   differs;
  logic [DATA_W-1:0]     status, rd_sel;

  // Widen addresses so range compares do not overflow when the register
  // range reaches the top of the address space.
  assign addr_ext = 32'(address);
  assign ptr_ext  = 32'(ptr);

  // ------------------------------------------------------------------
  // Write decode
  // ------------------------------------------------------------------
  assign wr_ptr      = load && (addr_ext == 32'(ADDR_PTR));
  assign wr_ctrl     = load && (addr_ext == 32'(ADDR_CTRL));
  assign commit_req  = wr_ctrl && data_in[CTRL_COMMIT];
  assign in_range    = (addr_ext >= 32'(FIRST_ADDR)) && (addr_ext <= 32'(LAST_ADDR));
  assign above_range = (addr_ext > 32'(LAST_ADDR));
  assign lock_err    = load && in_range && locked;
  assign range_err   = load && above_range;

  // ------------------------------------------------------------------
  // Register slots
  // ------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    logic slot_wr;
    logic [DATA_W-1:0] slot_shadow;

    assign slot_wr = load && !locked && (addr_ext == 32'(FIRST_ADDR + i));

    cfg_reg_slot #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VALS[i*DATA_W +: DATA_W])
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (slot_wr),
      .wr_data   (data_in),
      .commit_en (commit_en),
      .shadow    (slot_shadow),
      .active    (active_regs[i*DATA_W +: DATA_W]),
      .differs   (differs[i])
    );
  end

  assign dirty = |differs;

  // ------------------------------------------------------------------
  // Commit sequencer: state register / next state / outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (SYNC_COMMIT && commit_req) state_next = PENDING;
      PENDING: if (frame_sync)                state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The request edge itself moves IDLE->PENDING, so frame_sync in the
  // request cycle is never seen; repeated requests while PENDING are ignored.
  always_comb begin
    commit_en      = 1'b0;
    commit_pending = 1'b0;
    unique case (state)
      IDLE:    commit_en = !SYNC_COMMIT && commit_req;
      PENDING: begin
        commit_pending = 1'b1;
        commit_en      = frame_sync;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // Readback selection
  // ------------------------------------------------------------------
  always_comb begin
    status           = '0;
    status[ST_PEND]  = commit_pending;
    status[ST_LOCK]  = locked;
    status[ST_ERR]   = wr_err;
    status[ST_DIRTY] = dirty;
  end

  always_comb begin
    rd_sel = '0;
    if (ptr_ext == 32'(ADDR_PTR) || ptr_ext == 32'(ADDR_CTRL)) rd_sel = status;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ptr_ext == 32'(FIRST_ADDR + i)) rd_sel = active_regs[i*DATA_W +: DATA_W];
    end
  end

  // ------------------------------------------------------------------
  // Pointer, readback and flag registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      data_valid <= rd_en;
      if (rd_en) data_out <= rd_sel;

      // A pointer write overrides the post-read increment.
      if (wr_ptr)     ptr <= data_in[ADDR_W-1:0];
      else if (rd_en) ptr <= ptr + ADDR_W'(1);

      if (wr_ctrl && data_in[CTRL_LOCK]) locked <= 1'b1;

      // A new error takes priority over a clear in the same cycle.
      if (lock_err || range_err)              wr_err <= 1'b1;
      else if (wr_ctrl && data_in[CTRL_CLR_ERR]) wr_err <= 1'b0;
    end
  end

endmodule
